add: RTL and testbench

- Registered signed two's-complement adder, default 14-bit datapath.
- Sits in the datapath sandbox between sample sources and downstream logic/result capture.
- Optional overflow flag, saturation mode and a second pipeline stage that splits the carry chain, for timing.

---
 rtl/add.sv | 120 ++++++++++++
 tb/tb_add.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/add.sv
// Registered signed two's-complement adder.
//
// Adds two dim-bit signed operands and registers the dim-bit result together
// with a signed-overflow flag. On overflow the result either wraps modulo
// 2^dim (SATURATE=0) or clamps to the signed min/max (SATURATE=1). With
// PIPE=2 the carry chain is split across two registers: the lower half and
// its carry-out are registered first, then the upper half is completed.
//
// Parameters:
//   dim      operand/result width, 2..64
//   PIPE     latency in cycles, 1 or 2 (any value other than 1 builds the
//            two-stage version)
//   SATURATE 0 = wrap, 1 = clamp on overflow
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high; clears every register
//   a    operand A, signed
//   b    operand B, signed
//   sum  registered result, signed
//   ovf  registered signed-overflow flag, aligned with sum
module add #(
  parameter int dim      = 14,
  parameter int PIPE     = 1,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [dim-1:0] a,
  input  logic signed [dim-1:0] b,
  output logic signed [dim-1:0] sum,
  output logic                  ovf
);

  localparam logic signed [dim-1:0] MAX_V = {1'b0, {(dim-1){1'b1}}};
  localparam logic signed [dim-1:0] MIN_V = {1'b1, {(dim-1){1'b0}}};

  // Same-sign operands whose truncated result flips sign have overflowed.
  function automatic logic ovf_fn(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // On overflow both operands share a's sign, so a's sign picks the rail.
  function automatic logic signed [dim-1:0] sat_fn(
    input logic signed [dim-1:0] wrapped,
    input logic                  sa,
    input logic                  ov
  );
    if ((SATURATE != 0) && ov)
      return sa ? MIN_V : MAX_V;
    return wrapped;
  endfunction

  generate
    if (PIPE == 1) begin : g_pipe1
      logic signed [dim-1:0] wrap_p0;
      logic                  ovf_p0;

      assign wrap_p0 = a + b;
      assign ovf_p0  = ovf_fn(a[dim-1], b[dim-1], wrap_p0[dim-1]);

      // ---- stage p0 -> output register ----
      always_ff @(posedge clk) begin
        if (rst) begin
          sum <= '0;
          ovf <= 1'b0;
        end else begin
          sum <= sat_fn(wrap_p0, a[dim-1], ovf_p0);
          ovf <= ovf_p0;
        end
      end
    end else begin : g_pipe2
      localparam int LO = (dim + 1) / 2;
      localparam int HI = dim - LO;

      logic [LO:0]   lo_p0;
      logic [LO-1:0] lo_p1;
      logic          cy_p1;
      logic [HI-1:0] ahi_p1;
      logic [HI-1:0] bhi_p1;
      logic [HI-1:0] hi_p1;
      logic signed [dim-1:0] wrap_p1;
      logic                  ovf_p1;

      // Lower half computed one bit wider so its carry-out is captured.
      assign lo_p0 = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]};

      // ---- stage p0 -> p1: lower partial sum, carry, upper operand halves ----
      always_ff @(posedge clk) begin
        if (rst) begin
          lo_p1  <= '0;
          cy_p1  <= 1'b0;
          ahi_p1 <= '0;
          bhi_p1 <= '0;
        end else begin
          lo_p1  <= lo_p0[LO-1:0];
          cy_p1  <= lo_p0[LO];
          ahi_p1 <= a[dim-1:LO];
          bhi_p1 <= b[dim-1:LO];
        end
      end

      assign hi_p1   = ahi_p1 + bhi_p1 + HI'(cy_p1);
      assign wrap_p1 = {hi_p1, lo_p1};
      assign ovf_p1  = ovf_fn(ahi_p1[HI-1], bhi_p1[HI-1], hi_p1[HI-1]);

      // ---- stage p1 -> output register: upper half, overflow, saturation ----
      always_ff @(posedge clk) begin
        if (rst) begin
          sum <= '0;
          ovf <= 1'b0;
        end else begin
          sum <= sat_fn(wrap_p1, ahi_p1[HI-1], ovf_p1);
          ovf <= ovf_p1;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_add.sv
// Testbench for add: four instances (PIPE 1/2 x SATURATE 0/1) share the
// stimulus. Each driven cycle pushes the expected result into a per-latency
// queue tagged with the clock edge at which it must appear; a monitor pops
// and compares after every rising edge.
module tb_add;

  localparam int W = 14;
  localparam logic signed [W-1:0] MAXV = 14'sh1FFF;
  localparam logic signed [W-1:0] MINV = 14'sh2000;

  typedef struct {
    int                  due;
    logic signed [W-1:0] w;
    logic signed [W-1:0] s;
    logic                o;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [W-1:0] a = '0;
  logic signed [W-1:0] b = '0;
  logic signed [W-1:0] sum_p1w, sum_p1s, sum_p2w, sum_p2s;
  logic                ovf_p1w, ovf_p1s, ovf_p2w, ovf_p2s;

  exp_t q1[$];
  exp_t q2[$];
  int   edge_cnt = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  bit   started  = 1'b0;
  bit   drain    = 1'b0;

  always #5 clk = ~clk;

  add #(.dim(W), .PIPE(1), .SATURATE(0)) u_p1w (.clk(clk), .rst(rst), .a(a), .b(b), .sum(sum_p1w), .ovf(ovf_p1w));
  add #(.dim(W), .PIPE(1), .SATURATE(1)) u_p1s (.clk(clk), .rst(rst), .a(a), .b(b), .sum(sum_p1s), .ovf(ovf_p1s));
  add #(.dim(W), .PIPE(2), .SATURATE(0)) u_p2w (.clk(clk), .rst(rst), .a(a), .b(b), .sum(sum_p2w), .ovf(ovf_p2w));
  add #(.dim(W), .PIPE(2), .SATURATE(1)) u_p2s (.clk(clk), .rst(rst), .a(a), .b(b), .sum(sum_p2s), .ovf(ovf_p2s));

  task automatic chk_s(input string nm, input logic signed [W-1:0] act, input logic signed [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %0d, expected %0d", nm, edge_cnt, act, exp);
    end
  endtask

  task automatic chk_o(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %b, expected %b", nm, edge_cnt, act, exp);
    end
  endtask

  // Integer reference used for the random streaming phase.
  function automatic exp_t ref_add(input int x, input int y, input int due);
    exp_t e;
    int   t;
    t     = x + y;
    e.due = due;
    e.o   = (t > 8191) || (t < -8192);
    e.w   = t[W-1:0];
    e.s   = e.o ? ((t > 0) ? MAXV : MINV) : t[W-1:0];
    return e;
  endfunction

  // Drive one cycle; expected values come from the caller.
  task automatic step(input logic signed [W-1:0] x, input logic signed [W-1:0] y, input logic r,
                      input logic signed [W-1:0] ew, input logic signed [W-1:0] es, input logic eo);
    exp_t e;
    int   k;
    k = edge_cnt + 1;
    if (r) begin
      e = '{due: k, w: '0, s: '0, o: 1'b0};
      q1.push_back(e);
      // Anything still in flight in the two-stage pipe is flushed.
      while (q2.size() > 0 && q2[$].due >= k) void'(q2.pop_back());
      q2.push_back(e);
      e.due = k + 1;
      q2.push_back(e);
      started = 1'b1;
    end else begin
      e = '{due: k, w: ew, s: es, o: eo};
      q1.push_back(e);
      e.due = k + 1;
      q2.push_back(e);
    end
    a   = x;
    b   = y;
    rst = r;
    @(negedge clk);
  endtask

  // Monitor: one comparison set per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      if (started) begin
        if (q1.size() > 0 && q1[0].due == edge_cnt) begin
          e = q1.pop_front();
          chk_s("p1_wrap_sum", sum_p1w, e.w);
          chk_o("p1_wrap_ovf", ovf_p1w, e.o);
          chk_s("p1_sat_sum",  sum_p1s, e.s);
          chk_o("p1_sat_ovf",  ovf_p1s, e.o);
        end else if (!drain) begin
          n_tests++;
          n_fail++;
          $display("FAIL p1_sequence edge %0d: got no expected entry, required one due now", edge_cnt);
        end
        if (q2.size() > 0 && q2[0].due == edge_cnt) begin
          e = q2.pop_front();
          chk_s("p2_wrap_sum", sum_p2w, e.w);
          chk_o("p2_wrap_ovf", ovf_p2w, e.o);
          chk_s("p2_sat_sum",  sum_p2s, e.s);
          chk_o("p2_sat_ovf",  ovf_p2s, e.o);
        end else if (!drain) begin
          n_tests++;
          n_fail++;
          $display("FAIL p2_sequence edge %0d: got no expected entry, required one due now", edge_cnt);
        end
      end
    end
  end

  initial begin
    logic signed [W-1:0] ra, rb;
    exp_t e;
    int   waited;

    @(negedge clk);
    // Reset held two cycles with live operands, then released.
    step(14'sd5, 14'sd6, 1'b1, 14'sd0, 14'sd0, 1'b0);
    step(14'sd5, 14'sd6, 1'b1, 14'sd0, 14'sd0, 1'b0);
    step(14'sd5, 14'sd6, 1'b0, 14'sd11, 14'sd11, 1'b0);
    step(14'sd5, 14'sd6, 1'b0, 14'sd11, 14'sd11, 1'b0);

    // Directed vectors: a, b, wrapped sum, saturated sum, ovf.
    step( 14'sd10,   -14'sd11,  0, -14'sd1,    -14'sd1,    1'b0);
    step( 14'sd100,   14'sd23,  0,  14'sd123,   14'sd123,  1'b0);
    step( MAXV,       14'sd1,   0,  MINV,       MAXV,      1'b1);
    step( MINV,      -14'sd1,   0,  MAXV,       MINV,      1'b1);
    step( MAXV,       MINV,     0, -14'sd1,    -14'sd1,    1'b0);
    step( MINV,       14'sd0,   0,  MINV,       MINV,      1'b0);
    step( MINV,       MINV,     0,  14'sd0,     MINV,      1'b1);
    step( MAXV,       MAXV,     0, -14'sd2,     MAXV,      1'b1);
    step(-14'sd1,     14'sd1,   0,  14'sd0,     14'sd0,    1'b0);
    step( 14'sd4095,  14'sd4097,0,  MINV,       MAXV,      1'b1);
    step(-14'sd100,  -14'sd200, 0, -14'sd300,  -14'sd300,  1'b0);
    step( 14'sd127,   14'sd1,   0,  14'sd128,   14'sd128,  1'b0);

    // Reset mid-stream: the overflowing pair is in flight in the two-stage pipe.
    step( 14'sd100,   14'sd23,  0,  14'sd123,   14'sd123,  1'b0);
    step( MAXV,       14'sd1,   0,  MINV,       MAXV,      1'b1);
    step( 14'sd7,     14'sd7,   1,  14'sd0,     14'sd0,    1'b0);
    step( 14'sd10,   -14'sd11,  0, -14'sd1,    -14'sd1,    1'b0);
    step( MINV,      -14'sd1,   0,  MAXV,       MINV,      1'b1);

    // Streaming: a new random pair every cycle.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      e  = ref_add(int'(ra), int'(rb), 0);
      step(ra, rb, 1'b0, e.w, e.s, e.o);
    end

    // Let the pipes empty, bounded.
    drain  = 1'b1;
    waited = 0;
    while ((q1.size() > 0 || q2.size() > 0) && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (q1.size() > 0 || q2.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d/%0d entries left, expected 0/0", q1.size(), q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
